// File: rtl/painterengine_gpu_reader_scheduler.sv
// Round-robin job scheduler for the shared GPU DMA reader: arbitrates four requesters,
// re-arms the reader through its reset for each job, and returns ack/err per requester.
module painterengine_gpu_reader_scheduler #(
    parameter int REARM_CYCLES  = 2,
    parameter int WATCHDOG_BITS = 20
) (
    input  logic        i_wire_clock,
    input  logic        i_wire_resetn,
    input  logic [3:0]  i_wire_req,
    output logic [3:0]  o_wire_grant,
    output logic [3:0]  o_wire_ack,
    output logic [3:0]  o_wire_err,
    output logic [2:0]  o_wire_err_type,
    output logic        o_wire_busy,
    output logic [31:0] o_wire_job_cycles,
    output logic        o_wire_reader_resetn,
    output logic [3:0]  o_wire_reader_router,
    input  logic        i_wire_reader_done,
    input  logic        i_wire_reader_error,
    input  logic [2:0]  i_wire_reader_error_type
);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_ARM  = 3'd1;
    localparam logic [2:0] ST_RUN  = 3'd2;
    localparam logic [2:0] ST_ACK  = 3'd3;
    localparam logic [2:0] ST_GAP  = 3'd4;

    localparam logic [2:0]               WDOG_ERR_CODE = 3'b110;
    localparam logic [WATCHDOG_BITS-1:0] WDOG_ONE      = WATCHDOG_BITS'(1);

    logic [2:0]               state;
    logic [3:0]               grant_q;
    logic [3:0]               router_q;
    logic                     reader_resetn_q;
    logic [3:0]               arm_cnt;
    logic [31:0]              job_cnt;
    logic [WATCHDOG_BITS-1:0] wdog;
    logic [1:0]               last_idx;
    logic [3:0]               ack_q;
    logic [3:0]               err_q;
    logic [2:0]               err_type_q;
    logic                     busy_q;
    logic [31:0]              job_cycles_q;

    function automatic logic [1:0] onehot_index(input logic [3:0] oh);
        logic [1:0] idx;
        idx = 2'd0;
        for (int b = 0; b < 4; b++) begin
            if (oh[b]) idx = 2'(b);
        end
        return idx;
    endfunction

    // Circular priority search starting just after the last served requester.
    logic       pick_valid;
    logic [1:0] pick_idx;
    logic [1:0] cand;
    always_comb begin
        // NOTE: every variable written here gets a default first, so no latch is inferred.
        pick_valid = 1'b0;
        pick_idx   = 2'd0;
        cand       = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            cand = last_idx + 2'(k);
            if (!pick_valid && i_wire_req[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    logic [3:0] pick_onehot;
    assign pick_onehot = 4'b0001 << pick_idx;

    logic [31:0]              job_cnt_inc;
    logic [WATCHDOG_BITS-1:0] wdog_inc;
    logic                     wdog_expire;
    logic                     run_end;
    logic                     run_fail;
    logic [2:0]               run_code;

    assign job_cnt_inc = (&job_cnt) ? job_cnt : job_cnt + 32'd1;
    assign wdog_inc    = wdog + WDOG_ONE;
    assign wdog_expire = &wdog_inc;

    // Error outranks done, done outranks the watchdog.
    assign run_end  = i_wire_reader_error | i_wire_reader_done | wdog_expire;
    assign run_fail = i_wire_reader_error | ~i_wire_reader_done;
    assign run_code = i_wire_reader_error ? i_wire_reader_error_type :
                      i_wire_reader_done  ? 3'b000 : WDOG_ERR_CODE;

    always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
        if (!i_wire_resetn) begin
            state           <= ST_IDLE;
            grant_q         <= 4'b0000;
            router_q        <= 4'b0000;
            reader_resetn_q <= 1'b0;
            arm_cnt         <= 4'd0;
            job_cnt         <= 32'd0;
            wdog            <= '0;
            last_idx        <= 2'd3;
            ack_q           <= 4'b0000;
            err_q           <= 4'b0000;
            err_type_q      <= 3'b000;
            busy_q          <= 1'b0;
            job_cycles_q    <= 32'd0;
        end else begin
            // NOTE: state updates use non-blocking assignments so every register sees pre-edge values.
            ack_q <= 4'b0000;
            err_q <= 4'b0000;
            case (state)
                ST_IDLE: begin
                    reader_resetn_q <= 1'b0;
                    if (pick_valid) begin
                        state    <= ST_ARM;
                        grant_q  <= pick_onehot;
                        router_q <= pick_onehot;
                        arm_cnt  <= 4'(REARM_CYCLES);
                        busy_q   <= 1'b1;
                    end
                end
                ST_ARM: begin
                    if (arm_cnt == 4'd1) begin
                        state           <= ST_RUN;
                        reader_resetn_q <= 1'b1;
                        job_cnt         <= 32'd0;
                        wdog            <= '0;
                    end else begin
                        arm_cnt <= arm_cnt - 4'd1;
                    end
                end
                ST_RUN: begin
                    job_cnt <= job_cnt_inc;
                    wdog    <= wdog_inc;
                    if (run_end) begin
                        state           <= ST_ACK;
                        reader_resetn_q <= 1'b0;
                        ack_q           <= grant_q;
                        err_q           <= grant_q & {4{run_fail}};
                        err_type_q      <= run_code;
                        job_cycles_q    <= job_cnt_inc;
                    end
                end
                ST_ACK: begin
                    state    <= ST_GAP;
                    last_idx <= onehot_index(grant_q);
                    grant_q  <= 4'b0000;
                    router_q <= 4'b0000;
                end
                ST_GAP: begin
                    state  <= ST_IDLE;
                    busy_q <= 1'b0;
                end
                default: begin
                    state           <= ST_IDLE;
                    grant_q         <= 4'b0000;
                    router_q        <= 4'b0000;
                    reader_resetn_q <= 1'b0;
                    busy_q          <= 1'b0;
                end
            endcase
        end
    end

    assign o_wire_grant         = grant_q;
    assign o_wire_ack           = ack_q;
    assign o_wire_err           = err_q;
    assign o_wire_err_type      = err_type_q;
    assign o_wire_busy          = busy_q;
    assign o_wire_job_cycles    = job_cycles_q;
    assign o_wire_reader_resetn = reader_resetn_q;
    assign o_wire_reader_router = router_q;

endmodule

// File: tb/tb_painterengine_gpu_reader_scheduler.sv
// Directed bench for the reader scheduler: a per-cycle vector table for one job, then
// hand-written sequences for rotation, reader errors, watchdog, resets and withdrawn requests.
module tb_painterengine_gpu_reader_scheduler;

    localparam int REARM = 2;
    localparam int WDOG  = 4;

    logic        clk;
    logic        rstn;
    logic [3:0]  req;
    logic [3:0]  grant;
    logic [3:0]  ack;
    logic [3:0]  err;
    logic [2:0]  err_type;
    logic        busy;
    logic [31:0] job_cycles;
    logic        rd_resetn;
    logic [3:0]  rd_router;
    logic        rd_done;
    logic        rd_error;
    logic [2:0]  rd_etype;

    painterengine_gpu_reader_scheduler #(
        .REARM_CYCLES  (REARM),
        .WATCHDOG_BITS (WDOG)
    ) dut (
        .i_wire_clock             (clk),
        .i_wire_resetn            (rstn),
        .i_wire_req               (req),
        .o_wire_grant             (grant),
        .o_wire_ack               (ack),
        .o_wire_err               (err),
        .o_wire_err_type          (err_type),
        .o_wire_busy              (busy),
        .o_wire_job_cycles        (job_cycles),
        .o_wire_reader_resetn     (rd_resetn),
        .o_wire_reader_router     (rd_router),
        .i_wire_reader_done       (rd_done),
        .i_wire_reader_error      (rd_error),
        .i_wire_reader_error_type (rd_etype)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn = 1'b0; req = 4'b0; rd_done = 1'b0; rd_error = 1'b0; rd_etype = 3'b0;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_grant"},   32'(grant),      32'h0);
        check({tag, "_router"},  32'(rd_router),  32'h0);
        check({tag, "_rresetn"}, 32'(rd_resetn),  32'h0);
        check({tag, "_ack"},     32'(ack),        32'h0);
        check({tag, "_err"},     32'(err),        32'h0);
        check({tag, "_errtype"}, 32'(err_type),   32'h0);
        check({tag, "_busy"},    32'(busy),       32'h0);
        check({tag, "_jobcyc"},  job_cycles,      32'h0);
    endtask

    // mode: 0 done, 1 error, 2 done+error together, 3 reader silent
    task automatic serve(input string tag, input logic [3:0] g, input int run_len, input int mode,
                         input logic [2:0] et, input bit drop_mid,
                         input logic [3:0] exp_err, input logic [2:0] exp_type);
        int n;
        n = 0;
        while (grant == 4'b0 && n < 10) begin step(); n++; end
        check({tag, "_grant"},      32'(grant),     32'(g));
        check({tag, "_router_arm"}, 32'(rd_router), 32'(g));
        check({tag, "_rresetn_arm"},32'(rd_resetn), 32'h0);
        check({tag, "_busy_arm"},   32'(busy),      32'h1);
        n = 0;
        while (rd_resetn == 1'b0 && n < 20) begin step(); n++; end
        check({tag, "_arm_cycles"}, 32'(n), 32'(REARM));
        for (int k = 1; k <= run_len; k++) begin
            if (drop_mid && k == 3) req = req & ~g;
            if (k == run_len) begin
                case (mode)
                    0: rd_done = 1'b1;
                    1: begin rd_error = 1'b1; rd_etype = et; end
                    2: begin rd_done = 1'b1; rd_error = 1'b1; rd_etype = et; end
                    default: ;
                endcase
            end
            step();
            if (k < run_len) check({tag, "_run_ack"}, 32'(ack), 32'h0);
        end
        check({tag, "_ack"},         32'(ack),       32'(g));
        check({tag, "_err"},         32'(err),       32'(exp_err));
        check({tag, "_errtype"},     32'(err_type),  32'(exp_type));
        check({tag, "_rresetn_ack"}, 32'(rd_resetn), 32'h0);
        check({tag, "_router_ack"},  32'(rd_router), 32'(g));
        rd_done = 1'b0; rd_error = 1'b0; rd_etype = 3'b0;
        req = req & ~g;
        step();
        check({tag, "_gap_grant"},   32'(grant),     32'h0);
        check({tag, "_gap_router"},  32'(rd_router), 32'h0);
        check({tag, "_gap_ack"},     32'(ack),       32'h0);
        check({tag, "_gap_err"},     32'(err),       32'h0);
        check({tag, "_jobcyc"},      job_cycles,     32'(run_len));
        check({tag, "_errtype_hold"},32'(err_type),  32'(exp_type));
        step();
        check({tag, "_idle_busy"},   32'(busy),      32'h0);
    endtask

    typedef struct {
        logic [3:0]  req;
        logic        done;
        logic [3:0]  grant;
        logic [3:0]  ack;
        logic [3:0]  err;
        logic        busy;
        logic        rresetn;
        logic        jc_chk;
        logic [31:0] jc;
    } vec_t;

    vec_t vecs[16];

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Single job: req 0001, done at RUN cycle 10 (edge 12), ARM on edges 0..1.
        vecs[0]  = '{4'b0001, 1'b0, 4'b0001, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b1, 32'd0};
        vecs[1]  = '{4'b0001, 1'b0, 4'b0001, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0, 32'd0};
        for (int i = 2; i <= 11; i++)
            vecs[i] = '{4'b0001, 1'b0, 4'b0001, 4'b0000, 4'b0000, 1'b1, 1'b1, 1'b0, 32'd0};
        vecs[12] = '{4'b0001, 1'b1, 4'b0001, 4'b0001, 4'b0000, 1'b1, 1'b0, 1'b0, 32'd0};
        vecs[13] = '{4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b1, 32'd10};
        vecs[14] = '{4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 32'd10};
        vecs[15] = '{4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 32'd10};

        do_reset();
        check_reset_values("reset");

        for (int i = 0; i < 16; i++) begin
            req     = vecs[i].req;
            rd_done = vecs[i].done;
            step();
            check($sformatf("vec%0d_grant", i),   32'(grant),     32'(vecs[i].grant));
            check($sformatf("vec%0d_router", i),  32'(rd_router), 32'(vecs[i].grant));
            check($sformatf("vec%0d_ack", i),     32'(ack),       32'(vecs[i].ack));
            check($sformatf("vec%0d_err", i),     32'(err),       32'(vecs[i].err));
            check($sformatf("vec%0d_busy", i),    32'(busy),      32'(vecs[i].busy));
            check($sformatf("vec%0d_rresetn", i), 32'(rd_resetn), 32'(vecs[i].rresetn));
            if (vecs[i].jc_chk)
                check($sformatf("vec%0d_jobcyc", i), job_cycles, vecs[i].jc);
        end
        rd_done = 1'b0;

        // Round-robin from reset: all four pending, each drops after its ack.
        do_reset();
        req = 4'b1111;
        serve("rr0", 4'b0001, 3, 0, 3'b000, 1'b0, 4'b0000, 3'b000);
        serve("rr1", 4'b0010, 4, 0, 3'b000, 1'b0, 4'b0000, 3'b000);
        serve("rr2", 4'b0100, 2, 0, 3'b000, 1'b0, 4'b0000, 3'b000);
        serve("rr3", 4'b1000, 5, 0, 3'b000, 1'b0, 4'b0000, 3'b000);
        step();
        check("rr_all_served_grant", 32'(grant), 32'h0);
        check("rr_all_served_busy",  32'(busy),  32'h0);

        // Reader error, then done+error together, then a clean done.
        req = 4'b0100;
        serve("rerr",  4'b0100, 6, 1, 3'b010, 1'b0, 4'b0100, 3'b010);
        req = 4'b0100;
        serve("rboth", 4'b0100, 3, 2, 3'b101, 1'b0, 4'b0100, 3'b101);
        req = 4'b0100;
        serve("rdone", 4'b0100, 1, 0, 3'b000, 1'b0, 4'b0000, 3'b000);

        // Watchdog: silent reader aborts after 2^4-1 RUN cycles.
        req = 4'b0001;
        serve("wdog", 4'b0001, 15, 3, 3'b000, 1'b0, 4'b0001, 3'b110);

        // Request withdrawn during RUN still completes and acks.
        req = 4'b0010;
        serve("drop", 4'b0010, 7, 1, 3'b011, 1'b1, 4'b0010, 3'b011);

        // Asynchronous reset in the middle of a RUN phase.
        req = 4'b1000;
        begin
            int n;
            n = 0;
            while (rd_resetn == 1'b0 && n < 20) begin step(); n++; end
            check("mid_reader_running", 32'(rd_resetn), 32'h1);
            step();
            step();
            #2;
            rstn = 1'b0;
            #1;
            check_reset_values("midrst");
            repeat (2) @(posedge clk);
            check("midrst_no_ack", 32'(ack), 32'h0);
            @(negedge clk);
            rstn = 1'b1;
        end
        serve("post_rst", 4'b1000, 5, 0, 3'b000, 1'b0, 4'b0000, 3'b000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/painterengine_gpu_reader_scheduler.md
# painterengine_gpu_reader_scheduler

Round-robin scheduler that shares the single-burst-engine GPU DMA reader among four requesters. It selects one pending requester and drives the reader's one-hot router and a dedicated reader reset, which re-arms the reader for every job. It waits for the reader's done or error, then returns a per-requester acknowledge with error status. Requester address/length/data/next buses connect directly to the reader; this block only sequences and arbitrates.

## Interface
- REARM_CYCLES, 2, cycles the reader is held in reset before each job; legal range 1..15.
- WATCHDOG_BITS, 20, RUN-state watchdog width; the job aborts when the counter reaches 2^WATCHDOG_BITS-1.

- i_wire_clock  in  1  clock
- i_wire_resetn  in  1  reset, asynchronous, active-low
- i_wire_req  in  4  per-requester job request; level, held until the matching ack
- o_wire_grant  out  4  one-hot current owner; 0 when idle
- o_wire_ack  out  4  one-cycle pulse on the owner's bit at job end
- o_wire_err  out  4  one-cycle pulse coincident with ack when the job failed
- o_wire_err_type  out  3  error code of the last completed job; held until the next completion
- o_wire_busy  out  1  high in every state except IDLE
- o_wire_job_cycles  out  32  RUN-state cycle count of the last completed job
- o_wire_reader_resetn  out  1  drives the reader's i_wire_resetn
- o_wire_reader_router  out  4  drives the reader's i_wire_router
- i_wire_reader_done  in  1  reader done level
- i_wire_reader_error  in  1  reader error level
- i_wire_reader_error_type  in  3  reader error code

## Operation
- States: IDLE, ARM, RUN, ACK, GAP.
- **IDLE**
  - Reader is held in reset and the router is 0.
  - If i_wire_req is nonzero, the winner is the first set bit searched circularly from (last_grant_index+1) mod 4.
  - The winner is registered into grant, the arm counter is loaded to REARM_CYCLES, and the next state is ARM.
- **ARM**
  - reader_resetn=0 and reader_router=grant, so the router is stable before reset release.
  - The counter decrements; when it reaches 1, the next state is RUN.
- **RUN**
  - reader_resetn=1 and router=grant.
  - job_cnt and the watchdog increment every cycle.
  - reader_error=1: err_type ← i_wire_reader_error_type, failed=1, go to ACK. Error wins if done and error are both high.
  - Otherwise, reader_done=1: err_type ← 0, failed=0, go to ACK.
  - Otherwise, watchdog at all-ones: err_type ← 3'b110, failed=1, go to ACK.
- **ACK**
  - ack=grant and err=grant&{4{failed}} for one cycle.
  - o_wire_job_cycles ← job_cnt; last_grant_index ← index(grant).
  - reader_resetn=0; go to GAP.
- **GAP**
  - One cycle with reader in reset, grant cleared, and no arbitration.
  - Gives requesters one cycle to drop req after ack. Go to IDLE.
- If req deasserts mid-job, the job still runs to completion and ack is still pulsed.
- If a requester keeps req high after ack, it is a new job and is served again after the other pending requesters, by rotation.
- err_type 3'b110 is reserved for the scheduler watchdog; codes 0..5 are passed through from the reader.
- job_cnt and the watchdog clear on entry to RUN. job_cnt is 32 bits and saturates at all-ones.

## Timing
- Reset (asynchronous) values:
  - reader_resetn=0, router=0, grant=0, ack=0, err=0, err_type=0, busy=0, job_cycles=0.
  - last_grant_index=3, so requester 0 has first priority.
  - State=IDLE.
- Reset asserted mid-job: the reader is forced into reset in the same instant and no ack is issued.
- req sampled high in IDLE at cycle 0:
  - ARM during cycles 1..REARM_CYCLES.
  - RUN from cycle REARM_CYCLES+1, with reader_resetn rising at that edge.
- Done/error sampled at RUN cycle D: ack at D+1, GAP at D+2, IDLE at D+3, earliest next ARM at D+4.
- Requester back-to-back overhead: REARM_CYCLES+3 cycles between one job's last RUN cycle and the next job's first RUN cycle.
- All outputs are registered; router and grant change only on IDLE→ARM and ACK→GAP.

## Test plan
- **Single job:** req=4'b0001, reader_done at RUN cycle 10 → router=0001 throughout ARM and RUN; reader_resetn low 2 cycles then high; ack=0001 and err=0 one cycle later; job_cycles=10.
- **Round-robin:** req=4'b1111 held; each requester drops req the cycle after its ack → grant order 0001, 0010, 0100, 1000; four acks; no requester served twice.
- **Reader error:** req=4'b0100, reader_error=1 with type 3'b010 → ack=0100, err=0100, err_type=010. Then done and error asserted together → err wins.
- **Watchdog:** WATCHDOG_BITS=4, reader silent → abort after 15 RUN cycles, err=grant, err_type=110, reader_resetn low in ACK.
- **Mid-job reset:** i_wire_resetn pulsed low during RUN → reader_resetn=0 asynchronously; all outputs at reset values; next req=1000 is served normally with job_cycles counting from 0.
- **Req withdrawn mid-job:** req=0010 dropped during RUN → job completes and ack=0010 is still pulsed; returns to IDLE with busy=0.
